uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter DELAY_FRAMES, default 234, meaning clock cycles per bit (27 MHz / 115200 baud).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL provide port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port dataValid  input  1  producer offers the byte on dataOut this cycle.
REQ-006 SHALL provide port dataOut  input  8  byte to transmit.
REQ-007 SHALL provide port dataReady  output  1  FIFO not full; a byte is accepted on any edge where dataValid and dataReady are both 1.
REQ-008 SHALL provide port tx  output  1  serial line; idle high.
REQ-009 SHALL provide port txBusy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 SHALL provide port fifoCount  output  5  number of bytes held in the FIFO, excluding the byte currently being shifted.

Function
REQ-011 SHALL transmit 8N1 frames: one start bit (0), eight data bits LSB first, and one stop bit (1).
REQ-012 SHALL hold each bit for exactly DELAY_FRAMES cycles, so one frame takes 10*DELAY_FRAMES cycles.
REQ-013 SHALL register tx; it SHALL be a flop output with no combinational path from inputs.
REQ-014 SHALL implement the FSM states IDLE, START_BIT, DATA_BITS and STOP_BIT.
REQ-015 IDLE: tx=1; when the FIFO is non-empty, SHALL pop the head entry into the shift register, drive tx=0, reset the bit counter, and go to START_BIT on the same edge.
REQ-016 START_BIT: after DELAY_FRAMES cycles, SHALL drive tx=shift[0] and go to DATA_BITS.
REQ-017 DATA_BITS: every DELAY_FRAMES cycles, SHALL shift right and drive the next bit; after bit 7 completes, SHALL drive tx=1 and go to STOP_BIT.
REQ-018 STOP_BIT: after DELAY_FRAMES cycles, if the FIFO is non-empty SHALL pop the next entry and drive tx=0 (START_BIT) on that edge with no idle gap; otherwise SHALL return to IDLE.
REQ-019 Latency: when a byte is accepted at edge k into an empty FIFO with the FSM idle, tx SHALL go low at edge k+1.
REQ-020 The baud counter SHALL be $clog2(DELAY_FRAMES)+1 bits wide and SHALL count 0..DELAY_FRAMES-1, then wrap.
REQ-021 The FIFO SHALL be a circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
REQ-022 dataReady SHALL equal (fifoCount != FIFO_DEPTH).
REQ-023 A write while full SHALL be ignored, even when a pop occurs on the same edge; the producer SHALL see dataReady=0.
REQ-024 On a simultaneous push and pop (not full), fifoCount SHALL be unchanged and both pointers SHALL advance.
REQ-025 Changes to dataOut and dataValid during a frame SHALL NOT affect the byte being shifted.

Reset
REQ-026 On rst_n=0, the block SHALL immediately (asynchronously) set tx=1, txBusy=0, fifoCount=0, dataReady=1, FSM=IDLE, pointers=0 and counters=0.
REQ-027 A reset mid-frame SHALL abort the frame, discard all FIFO contents, and SHALL NOT drive a glitch low on tx.
REQ-028 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification (DELAY_FRAMES=4, FIFO_DEPTH=4 unless stated)
REQ-029 The bench SHALL check: single 0x55 push while idle -> tx low at the next edge, then the bit sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; txBusy falls after 40 cycles.
REQ-030 The bench SHALL check: push 0xA3 then 0x0F back-to-back -> two contiguous frames totalling 80 cycles, with the stop bit of the first frame followed directly by the start bit of the second.
REQ-031 The bench SHALL check: 6 pushes with dataValid held high while the first frame is active -> 1 byte shifting plus 4 queued, dataReady=0, the 6th byte accepted only after the next pop; all bytes are transmitted in order.
REQ-032 The bench SHALL check: FIFO full plus a pop on the same edge as an offered write -> the write is refused and fifoCount goes 4->3.
REQ-033 The bench SHALL check: rst_n pulsed low during data bit 3 of 0x00 -> tx=1 within the same cycle, fifoCount=0, and the next pushed byte 0xFF transmits as a clean frame.
REQ-034 The bench SHALL check: the default DELAY_FRAMES=234 with byte 0x41 -> each bit is exactly 234 cycles and a UART receiver at the same rate decodes 0x41.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing fed by a small circular-buffer FIFO.
// tx is a flop; back-to-back frames start on the same edge the previous stop bit ends.
module uart_tx #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dataValid,
  input  logic [7:0] dataOut,
  output logic       dataReady,
  output logic       tx,
  output logic       txBusy,
  output logic [4:0] fifoCount
);

  localparam int CNT_W = $clog2(DELAY_FRAMES) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START_BIT = 2'd1;
  localparam logic [1:0] DATA_BITS = 2'd2;
  localparam logic [1:0] STOP_BIT  = 2'd3;

  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [4:0]       countReg;

  logic [1:0]       stateReg;
  logic [CNT_W-1:0] baudCntReg;
  logic [2:0]       bitIdxReg;
  logic [7:0]       shiftReg;
  logic             txReg;

  logic fifoFull;
  logic fifoEmpty;
  logic baudDone;
  logic push;
  logic pop;

  assign fifoFull  = (countReg == DEPTH_CNT);
  assign fifoEmpty = (countReg == 5'd0);
  assign baudDone  = (baudCntReg == BAUD_LAST);
  // A full FIFO refuses writes even if a pop frees a slot on the same edge.
  assign push      = dataValid && !fifoFull;
  assign pop       = !fifoEmpty && ((stateReg == IDLE) || ((stateReg == STOP_BIT) && baudDone));

  // Storage carries no reset so it maps onto RAM; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtrReg] <= dataOut;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (push) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
      end
      if (pop) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
      countReg <= countReg + 5'(push) - 5'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      baudCntReg <= '0;
      bitIdxReg  <= '0;
      shiftReg   <= '0;
      txReg      <= 1'b1;
    end else begin
      case (stateReg)
        IDLE: begin
          txReg <= 1'b1;
          if (pop) begin
            shiftReg   <= fifoMem[rdPtrReg];
            txReg      <= 1'b0;
            baudCntReg <= '0;
            stateReg   <= START_BIT;
          end
        end
        START_BIT: begin
          if (baudDone) begin
            baudCntReg <= '0;
            bitIdxReg  <= '0;
            txReg      <= shiftReg[0];
            stateReg   <= DATA_BITS;
          end else begin
            baudCntReg <= baudCntReg + CNT_W'(1);
          end
        end
        DATA_BITS: begin
          if (baudDone) begin
            baudCntReg <= '0;
            if (bitIdxReg == 3'd7) begin
              txReg    <= 1'b1;
              stateReg <= STOP_BIT;
            end else begin
              // shiftReg[1] is the bit that becomes the LSB after this shift
              shiftReg  <= {1'b0, shiftReg[7:1]};
              txReg     <= shiftReg[1];
              bitIdxReg <= bitIdxReg + 3'd1;
            end
          end else begin
            baudCntReg <= baudCntReg + CNT_W'(1);
          end
        end
        STOP_BIT: begin
          if (baudDone) begin
            baudCntReg <= '0;
            if (pop) begin
              shiftReg <= fifoMem[rdPtrReg];
              txReg    <= 1'b0;
              stateReg <= START_BIT;
            end else begin
              stateReg <= IDLE;
            end
          end else begin
            baudCntReg <= baudCntReg + CNT_W'(1);
          end
        end
        default: begin
          stateReg <= IDLE;
          txReg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx        = txReg;
  assign txBusy    = (stateReg != IDLE) || !fifoEmpty;
  assign dataReady = !fifoFull;
  assign fifoCount = countReg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-timeline model checked every cycle, line decoders, and literal frame patterns.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int D2    = 234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       dataValid;
  logic [7:0] dataOut;
  logic       dataReady;
  logic       tx;
  logic       txBusy;
  logic [4:0] fifoCount;

  logic       dataValid2;
  logic [7:0] dataOut2;
  logic       dataReady2;
  logic       tx2;
  logic       txBusy2;
  logic [4:0] fifoCount2;

  uart_tx #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .dataValid(dataValid), .dataOut(dataOut),
    .dataReady(dataReady), .tx(tx), .txBusy(txBusy), .fifoCount(fifoCount)
  );

  uart_tx dutSlow (
    .clk(clk), .rst_n(rst_n), .dataValid(dataValid2), .dataOut(dataOut2),
    .dataReady(dataReady2), .tx(tx2), .txBusy(txBusy2), .fifoCount(fifoCount2)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    nCompared++;
    if (act !== want) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Behavioural model: queue of accepted bytes plus a position within the current 10-bit frame.
  logic [7:0] mq[$];
  logic [7:0] expStarted[$];
  bit         mActive = 1'b0;
  int         mT      = 0;
  logic [7:0] mCur    = 8'h00;

  function automatic logic frameBit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit canPush;
    bit canPop;
    if (!rst_n) begin
      mq.delete();
      expStarted.delete();
      mActive = 1'b0;
      mT      = 0;
    end else begin
      canPush = dataValid && (mq.size() < DEPTH);
      canPop  = (mq.size() > 0) && (!mActive || (mT == 10*D - 1));
      if (mActive && (mT != 10*D - 1)) begin
        mT++;
      end else if (canPop) begin
        mCur    = mq.pop_front();
        mActive = 1'b1;
        mT      = 0;
        expStarted.push_back(mCur);
      end else begin
        mActive = 1'b0;
      end
      if (canPush) mq.push_back(dataOut);
    end
  end

  bit checkEn = 1'b0;
  always @(negedge clk) begin
    if (checkEn) begin
      check("m_tx",    32'(tx),        32'(mActive ? frameBit(mCur, mT / D) : 1'b1));
      check("m_busy",  32'(txBusy),    32'(mActive || (mq.size() > 0)));
      check("m_count", 32'(fifoCount), 32'(mq.size()));
      check("m_ready", 32'(dataReady), 32'(mq.size() < DEPTH));
    end
  end

  // Line decoders sample mid-bit, independent of the model's timeline.
  logic [7:0] rxLog[$];
  bit         rxBusy = 1'b0;
  int         rxCnt  = 0;
  logic [7:0] rxSh   = 8'h00;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxBusy = 1'b0;
    end else if (!rxBusy) begin
      if (tx === 1'b0) begin
        rxBusy = 1'b1;
        rxCnt  = 0;
      end
    end else begin
      rxCnt++;
      if ((rxCnt % D == D/2) && (rxCnt > D) && (rxCnt < 9*D)) begin
        rxSh = {tx, rxSh[7:1]};
      end else if (rxCnt == 9*D + D/2) begin
        rxBusy = 1'b0;
        check("rx_stop", 32'(tx), 32'd1);
        rxLog.push_back(rxSh);
        $display("rx byte 0x%02h at %0t", rxSh, $time);
        check("rx_frame_expected", 32'(expStarted.size() > 0), 32'd1);
        if (expStarted.size() > 0) check("rx_byte", 32'(rxSh), 32'(expStarted.pop_front()));
      end
    end
  end

  logic [7:0] rxLog2[$];
  bit         rxBusy2 = 1'b0;
  int         rxCnt2  = 0;
  logic [7:0] rxSh2   = 8'h00;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxBusy2 = 1'b0;
    end else if (!rxBusy2) begin
      if (tx2 === 1'b0) begin
        rxBusy2 = 1'b1;
        rxCnt2  = 0;
      end
    end else begin
      rxCnt2++;
      if ((rxCnt2 % D2 == D2/2) && (rxCnt2 > D2) && (rxCnt2 < 9*D2)) begin
        rxSh2 = {tx2, rxSh2[7:1]};
      end else if (rxCnt2 == 9*D2 + D2/2) begin
        rxBusy2 = 1'b0;
        check("rx2_stop", 32'(tx2), 32'd1);
        rxLog2.push_back(rxSh2);
        $display("rx2 byte 0x%02h at %0t", rxSh2, $time);
      end
    end
  end

  task automatic waitIdle(input int maxc);
    int n;
    n = 0;
    while ((txBusy !== 1'b0) && (n < maxc)) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) check("idle_timeout", 32'(txBusy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic       p55 [10] = '{0,1,0,1,0,1,0,1,0,1};
  logic       p2  [20] = '{0,1,1,0,0,0,1,0,1,1, 0,1,1,1,1,0,0,0,0,1};
  logic       pFF [10] = '{0,1,1,1,1,1,1,1,1,1};
  logic       p41 [10] = '{0,1,0,0,0,0,0,1,0,1};
  logic [7:0] b [6];
  int         idx, guard, rxBase, density, bad;
  bit         acc, sawPop;

  initial begin
    rst_n = 1'b0; dataValid = 1'b0; dataOut = 8'h00; dataValid2 = 1'b0; dataOut2 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(txBusy), 32'd0);
    check("rst_count", 32'(fifoCount), 32'd0);
    check("rst_ready", 32'(dataReady), 32'd1);
    check("rst_tx_slow", 32'(tx2), 32'd1);
    rst_n = 1'b1; checkEn = 1'b1;
    @(negedge clk);

    // Single 0x55 while idle
    dataOut = 8'h55; dataValid = 1'b1;
    @(negedge clk); dataValid = 1'b0;
    check("t1_tx_before_start", 32'(tx), 32'd1);
    check("t1_count", 32'(fifoCount), 32'd1);
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      if (i < 40) check($sformatf("t1_sample%0d", i), 32'(tx), 32'(p55[i/4]));
      if (i == 39) check("t1_busy_last", 32'(txBusy), 32'd1);
      if (i == 40) check("t1_busy_fall", 32'(txBusy), 32'd0);
    end

    // 0xA3 then 0x0F back-to-back
    @(negedge clk);
    dataOut = 8'hA3; dataValid = 1'b1;
    @(negedge clk); dataOut = 8'h0F;
    @(negedge clk); dataValid = 1'b0;
    for (int i = 0; i < 81; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 80) check($sformatf("t2_sample%0d", i), 32'(tx), 32'(p2[i/4]));
      if (i == 79) check("t2_busy_last", 32'(txBusy), 32'd1);
      if (i == 80) check("t2_busy_fall", 32'(txBusy), 32'd0);
    end

    // Six pushes with dataValid held: fill, refuse on pop edge, accept after
    @(negedge clk);
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    rxBase = rxLog.size();
    idx = 0; guard = 0; sawPop = 1'b0;
    dataOut = b[0]; dataValid = 1'b1;
    while ((idx < 6) && (guard < 200)) begin
      acc = dataReady;
      @(negedge clk);
      guard++;
      if (acc) begin
        idx++;
        if (idx < 6) dataOut = b[idx];
        if (idx == 5) begin
          check("t3_full_count", 32'(fifoCount), 32'd4);
          check("t3_full_ready", 32'(dataReady), 32'd0);
          check("t3_full_busy", 32'(txBusy), 32'd1);
        end
      end else if ((idx == 5) && !sawPop && (fifoCount !== 5'd4)) begin
        sawPop = 1'b1;
        check("t3_pop_refused_count", 32'(fifoCount), 32'd3);
        check("t3_pop_ready", 32'(dataReady), 32'd1);
      end
    end
    dataValid = 1'b0;
    check("t3_all_accepted", 32'(idx), 32'd6);
    check("t3_saw_pop", 32'(sawPop), 32'd1);
    check("t3_sixth_accept_cycle", 32'(guard), 32'd43);
    check("t3_count_after", 32'(fifoCount), 32'd4);
    waitIdle(400);
    check("t3_rx_n", 32'(rxLog.size() - rxBase), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (rxBase + i < rxLog.size()) check($sformatf("t3_rx%0d", i), 32'(rxLog[rxBase+i]), 32'(b[i]));
    end

    // Reset during data bit 3 of 0x00 with two bytes queued
    @(negedge clk);
    dataOut = 8'h00; dataValid = 1'b1;
    @(negedge clk); dataOut = 8'h12;
    @(negedge clk); dataOut = 8'h34;
    @(negedge clk); dataValid = 1'b0;
    repeat (16) @(negedge clk);
    check("t4_in_bit3", 32'(tx), 32'd0);
    check("t4_queued", 32'(fifoCount), 32'd2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_tx", 32'(tx), 32'd1);
    check("t4_rst_count", 32'(fifoCount), 32'd0);
    check("t4_rst_busy", 32'(txBusy), 32'd0);
    check("t4_rst_ready", 32'(dataReady), 32'd1);
    @(negedge clk);
    check("t4_rst_tx_hold", 32'(tx), 32'd1);
    rxBase = rxLog.size();
    rst_n = 1'b1; dataOut = 8'hFF; dataValid = 1'b1;
    @(negedge clk); dataValid = 1'b0;
    check("t4_first_edge_accept", 32'(fifoCount), 32'd1);
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      if (i < 40) check($sformatf("t4_sample%0d", i), 32'(tx), 32'(pFF[i/4]));
      if (i == 40) check("t4_busy_fall", 32'(txBusy), 32'd0);
    end
    check("t4_rx_n", 32'(rxLog.size() - rxBase), 32'd1);
    if (rxLog.size() > rxBase) check("t4_rx_ff", 32'(rxLog[rxBase]), 32'hFF);

    // Random traffic with varying density, random data every cycle, one mid-cycle reset
    density = 50;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c % 300 == 0) density = int'($urandom_range(10, 100));
      dataValid = ($urandom_range(0, 99) < density);
      dataOut   = 8'($urandom);
      if (c == 777) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    dataValid = 1'b0;
    waitIdle(400);
    repeat (2) @(negedge clk);
    check("t5_all_frames_decoded", 32'(expStarted.size()), 32'd0);

    // Default rate, byte 0x41
    rxBase = rxLog2.size();
    @(negedge clk);
    dataOut2 = 8'h41; dataValid2 = 1'b1;
    @(negedge clk); dataValid2 = 1'b0;
    guard = 0;
    while ((tx2 !== 1'b0) && (guard < 10)) begin
      @(negedge clk);
      guard++;
    end
    check("t6_start_latency", 32'(guard), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int j = 0; j < D2; j++) begin
        if ((i != 0) || (j != 0)) @(negedge clk);
        if (tx2 !== p41[i]) bad++;
        if ((i == 9) && (j == D2 - 1)) check("t6_busy_last", 32'(txBusy2), 32'd1);
      end
      check($sformatf("t6_bit%0d_held_bad", i), 32'(bad), 32'd0);
    end
    @(negedge clk);
    check("t6_tx_idle", 32'(tx2), 32'd1);
    check("t6_busy_fall", 32'(txBusy2), 32'd0);
    repeat (2) @(negedge clk);
    check("t6_rx_n", 32'(rxLog2.size() - rxBase), 32'd1);
    if (rxLog2.size() > rxBase) check("t6_rx_41", 32'(rxLog2[rxBase]), 32'h41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
